// File: rtl/relu_maxpool2x2_stream.sv
// relu_maxpool2x2_stream: streaming ReLU + 2x2/stride-2 max-pool over a
// raster-order IEEE-754 single-precision feature map (WIDTH x HEIGHT).
// Optional feature macro: RELU_MAXPOOL_RELU_EN (defined = ReLU then pool,
// undefined = pool only with full sign-magnitude max).
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   valid_in   data_in valid this cycle (no backpressure)
//   data_in    conv+bias sample
//   valid_out  one-cycle pulse per completed 2x2 window
//   data_out   pooled value, held while valid_out is low
//   frame_done pulses with the last valid_out of a frame
module relu_maxpool2x2_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 56,
    parameter int HEIGHT     = 56
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_done
);

    localparam int HALF = WIDTH / 2;
    localparam int CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int RW   = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
    localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int SB   = DATA_WIDTH - 1;

    typedef logic [DATA_WIDTH-1:0] word_t;

    function automatic word_t act(input word_t x);
`ifdef RELU_MAXPOOL_RELU_EN
        act = x[SB] ? '0 : x;
`else
        act = x;
`endif
    endfunction

    // a strictly greater than b under the configured float ordering
    function automatic logic gt(input word_t a, input word_t b);
`ifdef RELU_MAXPOOL_RELU_EN
        // both operands are non-negative after ReLU
        gt = a[SB-1:0] > b[SB-1:0];
`else
        logic az;
        logic bz;
        az = (a[SB-1:0] == '0);
        bz = (b[SB-1:0] == '0);
        if (az && bz)
            gt = 1'b0;
        else if (a[SB] != b[SB])
            gt = ~a[SB];
        else if (!a[SB])
            gt = a[SB-1:0] > b[SB-1:0];
        else
            gt = a[SB-1:0] < b[SB-1:0];
`endif
    endfunction

    function automatic word_t vmax(input word_t a, input word_t b);
        vmax = gt(b, a) ? b : a;
    endfunction

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    word_t         hold_q, hold_d;
    word_t         out_q, out_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    word_t         rowbuf_q [HALF];
    word_t         rowbuf_d;
    logic          wr_en;
    logic [IW-1:0] idx;
    word_t         x;
    word_t         rb;
    logic          last_col;
    logic          last_row;

    always_comb begin
        x        = act(data_in);
        idx      = IW'(col_q >> 1);
        rb       = rowbuf_q[idx];
        // max of the current row's pair, reused for the row buffer write
        rowbuf_d = vmax(hold_q, x);
        last_col = (col_q == CW'(WIDTH - 1));
        last_row = (row_q == RW'(HEIGHT - 1));
        col_d    = col_q;
        row_d    = row_q;
        hold_d   = hold_q;
        out_d    = out_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        wr_en    = 1'b0;
        if (valid_in) begin
            if (!col_q[0]) begin
                hold_d = x;
            end else if (!row_q[0]) begin
                wr_en = 1'b1;
            end else begin
                out_d   = vmax(rb, rowbuf_d);
                valid_d = 1'b1;
                done_d  = last_col && last_row;
            end
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            hold_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Row buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (wr_en)
            rowbuf_q[idx] <= rowbuf_d;
    end

    assign valid_out  = valid_q;
    assign data_out   = out_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_relu_maxpool2x2_stream.sv
// tb_relu_maxpool2x2_stream: bench for relu_maxpool2x2_stream at 4x4 and 56x56.
// Honours RELU_MAXPOOL_RELU_EN in its reference model.
module tb_relu_maxpool2x2_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vin [2];
    logic [31:0] din [2];
    int          nvec = 0;
    int          nfail = 0;
    int          oc [2];
    int          fdc [2];
    logic [31:0] got [$];
    logic [31:0] fr [0:3135];

    always #5 clk = ~clk;

    function automatic logic [31:0] fm(input logic [31:0] v);
`ifdef RELU_MAXPOOL_RELU_EN
        return v[31] ? 32'h0 : v;
`else
        return v;
`endif
    endfunction

    // Float order as a signed integer: -mag for negatives, so +0 == -0.
    function automatic longint keyf(input logic [31:0] v);
        longint m;
        m = 0;
        m[30:0] = v[30:0];
        return v[31] ? -m : m;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int GW = (g == 0) ? 4 : 56;
        logic        vout;
        logic        fd;
        logic [31:0] dout;
        logic [31:0] pix [0:55][0:55];
        logic [31:0] cand [4];
        int          r = 0;
        int          c = 0;
        logic        exp_v = 1'b0;
        logic        exp_fd = 1'b0;
        longint      ekey = 0;

        relu_maxpool2x2_stream #(
            .DATA_WIDTH(32), .WIDTH(GW), .HEIGHT(GW)
        ) dut (
            .clk(clk), .rst(rst),
            .valid_in(vin[g]), .data_in(din[g]),
            .valid_out(vout), .data_out(dout), .frame_done(fd)
        );

        // Reference: store the frame, on each completed window take the
        // highest-ordered of its four activated samples.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                r = 0; c = 0; exp_v = 0; exp_fd = 0; ekey = 0;
                for (int i = 0; i < 4; i++) cand[i] = 32'h0;
            end else begin
                exp_v = 0;
                exp_fd = 0;
                if (vin[g]) begin
                    pix[r][c] = din[g];
                    if (r % 2 == 1 && c % 2 == 1) begin
                        cand[0] = fm(pix[r-1][c-1]);
                        cand[1] = fm(pix[r-1][c]);
                        cand[2] = fm(pix[r][c-1]);
                        cand[3] = fm(pix[r][c]);
                        ekey = keyf(cand[0]);
                        for (int i = 1; i < 4; i++)
                            if (keyf(cand[i]) > ekey) ekey = keyf(cand[i]);
                        exp_v = 1;
                        exp_fd = (r == GW-1) && (c == GW-1);
                    end
                    c++;
                    if (c == GW) begin
                        c = 0;
                        r++;
                        if (r == GW) r = 0;
                    end
                end
            end
        end

        always @(negedge clk) begin
            logic mem;
            nvec++;
            if (vout !== exp_v) begin
                nfail++;
                $display("FAIL valid_out[%0d]: got %b want %b", g, vout, exp_v);
            end
            nvec++;
            if (fd !== (exp_v & exp_fd)) begin
                nfail++;
                $display("FAIL frame_done[%0d]: got %b want %b", g, fd,
                         exp_v & exp_fd);
            end
            mem = 0;
            for (int i = 0; i < 4; i++)
                if (dout === cand[i] && keyf(dout) == ekey) mem = 1;
            nvec++;
            if (!mem) begin
                nfail++;
                $display("FAIL data_out[%0d]: got %h want max of %h %h %h %h",
                         g, dout, cand[0], cand[1], cand[2], cand[3]);
            end
            if (vout === 1'b1) begin
                oc[g]++;
                if (fd === 1'b1) fdc[g]++;
                if (g == 0) got.push_back(dout);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] b);
        nvec++;
        if (a !== b) begin
            nfail++;
            $display("FAIL %s: got %h want %h", nm, a, b);
        end
    endtask

    function automatic logic [31:0] gi(input int i);
        return (i < got.size()) ? got[i] : 32'hxxxxxxxx;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int g, input logic [31:0] d, input int gap);
        vin[g] = 1'b1;
        din[g] = d;
        idle(1);
        vin[g] = 1'b0;
        din[g] = $urandom;
        idle(gap);
    endtask

    task automatic frame(input int g, input int n, input int maxgap);
        for (int i = 0; i < n; i++)
            send(g, fr[i], $urandom_range(0, maxgap));
    endtask

    task automatic clr();
        got.delete();
        oc[0] = 0; oc[1] = 0;
        fdc[0] = 0; fdc[1] = 0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic ones_frame();
        for (int i = 0; i < 16; i++) fr[i] = 32'h3F800000;
        fr[5] = 32'h40000000;
    endtask

    task automatic chk_ones(input string nm, input int base);
        chk({nm, "_o0"}, gi(base), 32'h40000000);
        chk({nm, "_o1"}, gi(base + 1), 32'h3F800000);
        chk({nm, "_o2"}, gi(base + 2), 32'h3F800000);
        chk({nm, "_o3"}, gi(base + 3), 32'h3F800000);
    endtask

    function automatic logic [31:0] rnd();
        logic [31:0] pool [4];
        pool[0] = 32'h00000000; pool[1] = 32'h80000000;
        pool[2] = 32'h3F800000; pool[3] = 32'hBF800000;
        case ($urandom_range(0, 3))
            0: return pool[$urandom_range(0, 3)];
            1: return {1'b0, 31'($urandom)};
            2: return {1'b1, 31'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vin[0] = 0; vin[1] = 0; din[0] = 0; din[1] = 0;
        clr();
        #1 rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);

        // single 2.0 in window (0,0)
        clr();
        ones_frame();
        frame(0, 16, 0);
        idle(3);
        chk("t1_count", 32'(oc[0]), 32'd4);
        chk("t1_done", 32'(fdc[0]), 32'd1);
        chk_ones("t1", 0);

        // negative windows
        clr();
        for (int i = 0; i < 16; i++) fr[i] = 32'h3F800000;
        fr[0] = 32'hC0400000; fr[1] = 32'hBF800000;
        fr[4] = 32'h80000000; fr[5] = 32'hC0000000;
        fr[2] = 32'hC0400000; fr[3] = 32'hC0000000;
        fr[6] = 32'hBF800000; fr[7] = 32'hC0800000;
        frame(0, 16, 0);
        idle(3);
`ifdef RELU_MAXPOOL_RELU_EN
        chk("t2_neg_win", gi(0), 32'h00000000);
        chk("t3_neg_win", gi(1), 32'h00000000);
`else
        nvec++;
        if (gi(0) !== 32'h0 && gi(0) !== 32'h80000000) begin
            nfail++;
            $display("FAIL t3_zero_win: got %h want 00000000/80000000", gi(0));
        end
        chk("t3_neg_win", gi(1), 32'hBF800000);
`endif
        chk("t23_count", 32'(oc[0]), 32'd4);

        // idle gaps inside windows
        clr();
        ones_frame();
        frame(0, 16, 3);
        idle(3);
        chk("t4_count", 32'(oc[0]), 32'd4);
        chk_ones("t4", 0);

        // reset mid-frame, then a clean frame
        for (int i = 0; i < 7; i++) fr[i] = rnd();
        frame(0, 7, 1);
        pulse_rst();
        clr();
        ones_frame();
        frame(0, 16, 1);
        idle(3);
        chk("t5_count", 32'(oc[0]), 32'd4);
        chk("t5_done", 32'(fdc[0]), 32'd1);
        chk_ones("t5", 0);

        // back-to-back frames
        clr();
        ones_frame();
        frame(0, 16, 0);
        frame(0, 16, 0);
        idle(3);
        chk("t6_count", 32'(oc[0]), 32'd8);
        chk("t6_done", 32'(fdc[0]), 32'd2);
        chk_ones("t6a", 0);
        chk_ones("t6b", 4);

        // random frames with random gaps
        clr();
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 16; i++) fr[i] = rnd();
            frame(0, 16, $urandom_range(0, 3));
        end
        idle(3);
        chk("rnd_count", 32'(oc[0]), 32'd80);
        chk("rnd_done", 32'(fdc[0]), 32'd20);

        // full-size back-to-back frames
        clr();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3136; i++) fr[i] = rnd();
            frame(1, 3136, 0);
        end
        idle(3);
        chk("big_count", 32'(oc[1]), 32'd1568);
        chk("big_done", 32'(fdc[1]), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
